// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the serial digit adder: FSM state encodings and
// a constant-evaluable ceiling log2 used to size the digit counter.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit.sv
// One DIGIT_W-bit slice of the serial adder: a + b + ci -> {co, s}.
module digit_adder #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic [DIGIT_W:0] total_s;

  // Widen by one bit so the carry out lands in the top position.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
  end

  assign s  = total_s[DIGIT_W-1:0];
  assign co = total_s[DIGIT_W];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle add/subtract unit. Operands are consumed DIGIT_W bits per
// clock, least significant digit first, with the carry held in a flop
// between digits. A start/busy/done handshake frames each operation.
module serial_digit_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSTEP = WIDTH / DIGIT_W;
  localparam int CW    = clog2(NSTEP);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSTEP - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("serial_digit_adder: WIDTH must be at least 2");
  end
  if ((WIDTH % DIGIT_W) != 0) begin : g_digit_chk
    $error("serial_digit_adder: WIDTH must be a multiple of DIGIT_W");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT_W-1:0]       dig_s;
  logic                     dig_co_s;
  logic [WIDTH-1:0]         b_eff_s;
  logic [WIDTH+DIGIT_W-1:0] res_cat_s;
  logic [WIDTH-1:0]         res_shift_s;

  digit_adder #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .a  (a_sr_q[DIGIT_W-1:0]),
    .b  (b_sr_q[DIGIT_W-1:0]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co_s)
  );

  // Operand preparation and the result shift: new digit enters at the MSB end.
  always_comb begin
    b_eff_s     = sub ? ~b : b;
    res_cat_s   = {dig_s, res_q};
    res_shift_s = res_cat_s[WIDTH+DIGIT_W-1:DIGIT_W];
  end

  // Next-state logic for the FSM, datapath registers and result outputs.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the carry-in becomes 1 and cin is dropped.
          a_sr_d  = a;
          b_sr_d  = b_eff_s;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_eff_s[WIDTH-1];
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> DIGIT_W;
        b_sr_d  = b_sr_q >> DIGIT_W;
        res_d   = res_shift_s;
        carry_d = dig_co_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Final digit: publish the full result together with carry and overflow.
          state_d = ST_DONE;
          sum_d   = res_shift_s;
          cout_d  = dig_co_s;
          ovf_d   = (a_msb_q == b_msb_q) && (res_shift_s[WIDTH-1] != a_msb_q);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder: three instances (8/1, 8/4, 4/2).
module tb_serial_digit_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       starth, subh, cinh;
  logic [7:0] ah, bh;
  logic       busyh, doneh, couth, ovfh;
  logic [7:0] sumh;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  serial_digit_adder #(.WIDTH(8), .DIGIT_W(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

  serial_digit_adder #(.WIDTH(8), .DIGIT_W(4)) u_duth (
    .clk(clk), .rst(rst), .start(starth), .sub(subh), .a(ah), .b(bh), .cin(cinh),
    .busy(busyh), .done(doneh), .sum(sumh), .cout(couth), .overflow(ovfh));

  serial_digit_adder #(.WIDTH(4), .DIGIT_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic       r_busy, r_done, r_cout, r_ovf;
  logic [7:0] r_sum;

  // Select which instance's outputs the checking tasks look at.
  always_comb begin
    case (cur)
      0: begin r_busy = busy8; r_done = done8; r_sum = sum8; r_cout = cout8; r_ovf = ovf8; end
      1: begin r_busy = busyh; r_done = doneh; r_sum = sumh; r_cout = couth; r_ovf = ovfh; end
      default: begin r_busy = busy4; r_done = done4; r_sum = {4'h0, sum4}; r_cout = cout4; r_ovf = ovf4; end
    endcase
  end

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic sb,
                       input logic [7:0] av, input logic [7:0] bv, input logic c);
    case (sel)
      0: begin start8 = st; sub8 = sb; a8 = av; b8 = bv; cin8 = c; end
      1: begin starth = st; subh = sb; ah = av; bh = bv; cinh = c; end
      default: begin start4 = st; sub4 = sb; a4 = av[3:0]; b4 = bv[3:0]; cin4 = c; end
    endcase
  endtask

  // Present start for one edge, then scramble inputs to prove they were captured.
  task automatic start_op(input int sel, input logic sb, input logic [7:0] av,
                          input logic [7:0] bv, input logic c, input string nm);
    @(negedge clk);
    drive(sel, 1'b1, sb, av, bv, c);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, ~sb, ~av, ~bv, ~c);
    chk({nm, " busy after accept"}, 32'(r_busy), 32'd1);
    chk({nm, " done after accept"}, 32'(r_done), 32'd0);
  endtask

  task automatic wait_done(input int lat_exp, input string nm);
    int lat;
    bit overlap;
    bit gap;
    lat = 0;
    overlap = 1'b0;
    gap = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (r_busy && r_done) overlap = 1'b1;
      if (!r_busy && !r_done) gap = 1'b1;
    end while (!r_done && lat < 64);
    chk({nm, " latency"}, 32'(lat), 32'(lat_exp));
    chk({nm, " busy&done overlap"}, 32'(overlap), 32'd0);
    chk({nm, " busy dropped early"}, 32'(gap), 32'd0);
  endtask

  task automatic chk_res(input logic [7:0] es, input logic ec, input logic eo, input string nm);
    chk({nm, " sum"}, 32'(r_sum), 32'(es));
    chk({nm, " cout"}, 32'(r_cout), 32'(ec));
    chk({nm, " overflow"}, 32'(r_ovf), 32'(eo));
  endtask

  task automatic run_op(input int sel, input logic sb, input logic [7:0] av, input logic [7:0] bv,
                        input logic c, input logic [7:0] es, input logic ec, input logic eo,
                        input int lat, input string nm);
    start_op(sel, sb, av, bv, c, nm);
    wait_done(lat, nm);
    chk_res(es, ec, eo, nm);
    @(posedge clk);
    #1;
    chk({nm, " done one cycle"}, 32'(r_done), 32'd0);
    chk({nm, " idle busy"}, 32'(r_busy), 32'd0);
    chk({nm, " sum held"}, 32'(r_sum), 32'(es));
  endtask

  initial begin
    logic [3:0] bp, es4;
    logic [4:0] t;
    logic       ci, eo4;

    vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h20, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h3C, 8'h45, 1'b1, 8'h82, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      cur = s;
      #1;
      chk($sformatf("reset busy inst%0d", s), 32'(r_busy), 32'd0);
      chk($sformatf("reset done inst%0d", s), 32'(r_done), 32'd0);
      chk_res(8'h00, 1'b0, 1'b0, $sformatf("reset inst%0d", s));
    end
    @(negedge clk);
    rst = 1'b0;

    // Table of 8-bit, one-bit-per-cycle operations.
    cur = 0;
    for (int i = 0; i < 10; i++) begin
      run_op(0, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 8, $sformatf("vec%0d", i));
    end

    // Four bits per cycle: two-cycle latency.
    cur = 1;
    run_op(1, 1'b0, 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0, 2, "d4 add");
    run_op(1, 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, 2, "d4 sub");

    // Start pulsed mid-run is ignored; start held through DONE is accepted.
    cur = 0;
    start_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, "hs first");
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h7F, 8'h01, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_done(5, "hs first");
    chk_res(8'h00, 1'b1, 1'b0, "hs first");
    drive(0, 1'b1, 1'b1, 8'h20, 8'h10, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("hs b2b busy", 32'(r_busy), 32'd1);
    chk("hs b2b done", 32'(r_done), 32'd0);
    chk("hs b2b sum held", 32'(r_sum), 32'h00);
    wait_done(8, "hs second");
    chk_res(8'h10, 1'b1, 1'b0, "hs second");

    // Reset in the middle of a run clears everything at once.
    run_op(0, 1'b0, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1, 8, "pre reset");
    start_op(0, 1'b0, 8'h0F, 8'h01, 1'b0, "mid reset");
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mid reset busy", 32'(r_busy), 32'd0);
    chk("mid reset done", 32'(r_done), 32'd0);
    chk_res(8'h00, 1'b0, 1'b0, "mid reset");
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 8, "post reset");

    // Exhaustive 4-bit, two-bits-per-cycle sweep against an arithmetic model.
    cur = 2;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int c = 0; c < 2; c++) begin
          for (int s = 0; s < 2; s++) begin
            bp  = (s != 0) ? ~4'(bv) : 4'(bv);
            ci  = (s != 0) ? 1'b1 : 1'(c);
            t   = {1'b0, 4'(av)} + {1'b0, bp} + {4'h0, ci};
            es4 = t[3:0];
            eo4 = (4'(av) >> 3 == bp >> 3) && (es4[3] != 1'(av >> 3));
            run_op(2, 1'(s), 8'(av), 8'(bv), 1'(c), {4'h0, es4}, t[4], eo4, 2,
                   $sformatf("exh a=%0h b=%0h c=%0d s=%0d", av, bv, c, s));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
